// File: rtl/jtframe_mdpad_scan.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_mdpad_scan
// Function : 8-phase select scanner for Mega Drive DB9 pads with automatic
//            3-button / 6-button / absent detection, one word per player.
// Revision : 1.0
// ============================================================================
module jtframe_mdpad_scan #(
    parameter int PLAYERS  = 2,
    parameter int SEL_HOLD = 4,
    parameter int IDLE     = 64
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen,
    input  logic                    scan,
    input  logic [5:0]              din,
    output logic [1:0]              split,
    output logic                    mdsel,
    output logic [12*PLAYERS-1:0]   joy,
    output logic [PLAYERS-1:0]      present,
    output logic [PLAYERS-1:0]      six_btn,
    output logic                    sample
);

    localparam int              c_CNT_MAX     = (IDLE > SEL_HOLD) ? IDLE : SEL_HOLD;
    localparam int              c_CW          = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CW-1:0] c_IDLE_LAST   = c_CW'(IDLE - 1);
    localparam logic [c_CW-1:0] c_HOLD_LAST   = c_CW'(SEL_HOLD - 1);
    localparam logic [1:0]      c_LAST_PLAYER = 2'(PLAYERS - 1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_PHASE = 1'b1;

    logic [0:0]            r_state,   w_state;
    logic [c_CW-1:0]       r_cnt,     w_cnt;
    logic [2:0]            r_phase,   w_phase;
    logic [1:0]            r_player,  w_player;
    logic [1:0]            r_split,   w_split;
    logic                  r_mdsel,   w_mdsel;
    logic [11:0]           r_scr,     w_scr;
    logic                  r_pres,    w_pres;
    logic                  r_md6,     w_md6;
    logic [12*PLAYERS-1:0] r_joy,     w_joy;
    logic [PLAYERS-1:0]    r_present, w_present;
    logic [PLAYERS-1:0]    r_six,     w_six;
    logic                  r_sample,  w_sample;

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_phase   = r_phase;
        w_player  = r_player;
        w_split   = r_split;
        w_mdsel   = r_mdsel;
        w_scr     = r_scr;
        w_pres    = r_pres;
        w_md6     = r_md6;
        w_joy     = r_joy;
        w_present = r_present;
        w_six     = r_six;
        w_sample  = 1'b0;

        if (!scan) begin
            // abort: drop the partial player, keep the published outputs
            w_state  = c_ST_IDLE;
            w_cnt    = '0;
            w_phase  = 3'd0;
            w_player = 2'd0;
            w_mdsel  = 1'b1;
            w_scr    = 12'd0;
            w_pres   = 1'b0;
            w_md6    = 1'b0;
        end else if (cen) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_mdsel = 1'b1;
                    if (r_cnt == c_IDLE_LAST) begin
                        w_state  = c_ST_PHASE;
                        w_cnt    = '0;
                        w_phase  = 3'd0;
                        w_player = 2'd0;
                        w_split  = 2'd0;
                    end else begin
                        w_cnt = r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    if (r_cnt == c_HOLD_LAST) begin
                        w_cnt   = '0;
                        w_phase = r_phase + 3'd1;
                        // next phase is even exactly when the current one is odd
                        w_mdsel = r_phase[0];
                        case (r_phase)
                            3'd0: begin
                                w_scr[3:0] = ~din[3:0];
                                w_scr[5]   = ~din[4];
                                w_scr[6]   = ~din[5];
                            end
                            3'd1: begin
                                w_pres     = (din[3:2] == 2'b00);
                                w_scr[4]   = ~din[4];
                                w_scr[10]  = ~din[5];
                            end
                            3'd5: w_md6 = (din[3:0] == 4'd0);
                            3'd6: begin
                                if (r_md6) begin
                                    w_scr[9]  = ~din[0];
                                    w_scr[8]  = ~din[1];
                                    w_scr[7]  = ~din[2];
                                    w_scr[11] = ~din[3];
                                end
                            end
                            3'd7: begin
                                for (int i = 0; i < PLAYERS; i++) begin
                                    if (r_player == 2'(i)) begin
                                        w_joy[12*i +: 12] = r_pres ? r_scr : 12'd0;
                                        w_present[i]      = r_pres;
                                        w_six[i]          = r_pres & r_md6;
                                    end
                                end
                                w_scr  = 12'd0;
                                w_pres = 1'b0;
                                w_md6  = 1'b0;
                                if (r_player == c_LAST_PLAYER) begin
                                    w_state  = c_ST_IDLE;
                                    w_sample = 1'b1;
                                end else begin
                                    w_player = r_player + 2'd1;
                                    w_split  = r_player + 2'd1;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        w_cnt = r_cnt + c_CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_phase   <= 3'd0;
            r_player  <= 2'd0;
            r_split   <= 2'd0;
            r_mdsel   <= 1'b1;
            r_scr     <= 12'd0;
            r_pres    <= 1'b0;
            r_md6     <= 1'b0;
            r_joy     <= '0;
            r_present <= '0;
            r_six     <= '0;
            r_sample  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_phase   <= w_phase;
            r_player  <= w_player;
            r_split   <= w_split;
            r_mdsel   <= w_mdsel;
            r_scr     <= w_scr;
            r_pres    <= w_pres;
            r_md6     <= w_md6;
            r_joy     <= w_joy;
            r_present <= w_present;
            r_six     <= w_six;
            r_sample  <= w_sample;
        end
    end

    assign split   = r_split;
    assign mdsel   = r_mdsel;
    assign joy     = r_joy;
    assign present = r_present;
    assign six_btn = r_six;
    assign sample  = r_sample;

endmodule
`default_nettype wire
